// File: rtl/ysyx_25040111_arb_pkg.sv
// Shared encodings for the instruction-refill / load-store memory arbiter.
package ysyx_25040111_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   localparam logic [1:0] MASK_WORD = 2'b11;

endpackage

// File: rtl/ysyx_25040111_arb_pick.sv
// Winner selection between the refill and load/store requesters.
module ysyx_25040111_arb_pick
   import ysyx_25040111_arb_pkg::*;
#(
   parameter logic FAIR = 1'b1
) (
   input  logic if_req,
   input  logic ls_req,
   input  logic last,
   output logic valid,
   output logic win
);

   always_comb begin
      valid = if_req | ls_req;
      win   = OWN_IFU;
      // On a tie the LSU wins unless round-robin says it had the last turn.
      if (ls_req && (!if_req || !FAIR || last == OWN_IFU))
         win = OWN_LSU;
   end

endmodule

// File: rtl/ysyx_25040111_arb.sv
// Two-requester memory arbiter: one latched transaction at a time, response
// beats steered combinationally back to the owning requester.
module ysyx_25040111_arb
   import ysyx_25040111_arb_pkg::*;
#(
   parameter logic FAIR = 1'b1,
   parameter int   AW   = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic [7:0]    if_len,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   output logic          if_rlast,
   output logic          if_err,
   input  logic          ls_req,
   input  logic          ls_wen,
   input  logic [AW-1:0] ls_addr,
   input  logic [31:0]   ls_wdata,
   input  logic [1:0]    ls_mask,
   input  logic          ls_sign,
   output logic          ls_gnt,
   output logic          ls_done,
   output logic [31:0]   ls_rdata,
   output logic          ls_err,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_wen,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   output logic [1:0]    m_mask,
   output logic          m_sign,
   output logic [7:0]    m_len,
   input  logic          m_rvalid,
   input  logic [31:0]   m_rdata,
   input  logic          m_rlast,
   input  logic          m_bvalid,
   input  logic          m_err
);

   state_t        state_reg;
   logic          owner_reg;
   logic          last_reg;
   logic [7:0]    cnt_reg;
   logic          over_reg;
   logic          if_gnt_reg;
   logic          ls_gnt_reg;
   logic          m_valid_reg;
   logic          m_wen_reg;
   logic [AW-1:0] m_addr_reg;
   logic [31:0]   m_wdata_reg;
   logic [1:0]    m_mask_reg;
   logic          m_sign_reg;
   logic [7:0]    m_len_reg;

   logic pick_valid;
   logic pick_win;

   ysyx_25040111_arb_pick #(.FAIR(FAIR)) u_pick (
      .if_req (if_req),
      .ls_req (ls_req),
      .last   (last_reg),
      .valid  (pick_valid),
      .win    (pick_win)
   );

   logic in_resp;
   logic if_beat;
   logic at_last;
   logic term_beat;

   assign in_resp   = (state_reg == RESP);
   assign if_beat   = in_resp && (owner_reg == OWN_IFU) && m_rvalid;
   assign at_last   = (cnt_reg == m_len_reg);
   // over_reg marks beats past the terminal count, which never carry rlast.
   assign term_beat = at_last && !over_reg;

   assign if_rvalid = if_beat;
   assign if_rdata  = if_beat ? m_rdata : 32'd0;
   assign if_rlast  = if_beat && term_beat;
   assign if_err    = if_beat && (m_err || over_reg || (m_rlast != term_beat));

   assign ls_done   = in_resp && (owner_reg == OWN_LSU) && (m_wen_reg ? m_bvalid : m_rvalid);
   assign ls_rdata  = (ls_done && !m_wen_reg) ? m_rdata : 32'd0;
   assign ls_err    = ls_done && m_err;

   assign if_gnt  = if_gnt_reg;
   assign ls_gnt  = ls_gnt_reg;
   assign m_valid = m_valid_reg;
   assign m_wen   = m_wen_reg;
   assign m_addr  = m_addr_reg;
   assign m_wdata = m_wdata_reg;
   assign m_mask  = m_mask_reg;
   assign m_sign  = m_sign_reg;
   assign m_len   = m_len_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         owner_reg   <= OWN_IFU;
         last_reg    <= OWN_IFU;
         cnt_reg     <= 8'd0;
         over_reg    <= 1'b0;
         if_gnt_reg  <= 1'b0;
         ls_gnt_reg  <= 1'b0;
         m_valid_reg <= 1'b0;
         m_wen_reg   <= 1'b0;
         m_addr_reg  <= '0;
         m_wdata_reg <= 32'd0;
         m_mask_reg  <= 2'b00;
         m_sign_reg  <= 1'b0;
         m_len_reg   <= 8'd0;
      end else begin
         if_gnt_reg <= 1'b0;
         ls_gnt_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  state_reg   <= REQ;
                  owner_reg   <= pick_win;
                  last_reg    <= pick_win;
                  m_valid_reg <= 1'b1;
                  cnt_reg     <= 8'd0;
                  over_reg    <= 1'b0;
                  if (pick_win == OWN_LSU) begin
                     ls_gnt_reg  <= 1'b1;
                     m_wen_reg   <= ls_wen;
                     m_addr_reg  <= ls_addr;
                     m_wdata_reg <= ls_wdata;
                     m_mask_reg  <= ls_mask;
                     m_sign_reg  <= ls_sign;
                     m_len_reg   <= 8'd0;
                  end else begin
                     if_gnt_reg  <= 1'b1;
                     m_wen_reg   <= 1'b0;
                     m_addr_reg  <= if_addr;
                     m_wdata_reg <= 32'd0;
                     m_mask_reg  <= MASK_WORD;
                     m_sign_reg  <= 1'b0;
                     m_len_reg   <= if_len;
                  end
               end
            end
            REQ: begin
               if (m_ready) begin
                  m_valid_reg <= 1'b0;
                  state_reg   <= RESP;
               end
            end
            RESP: begin
               if (owner_reg == OWN_IFU) begin
                  if (m_rvalid) begin
                     // Counter parks at the terminal count so len=255 cannot wrap.
                     if (at_last) over_reg <= 1'b1;
                     else         cnt_reg  <= cnt_reg + 8'd1;
                     if (m_rlast) state_reg <= IDLE;
                  end
               end else if (ls_done) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25040111_arb.sv
// Directed bench for the memory arbiter; a FAIR=0 copy covers fixed priority.
module tb_ysyx_25040111_arb;
   import ysyx_25040111_arb_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        if_req, ls_req, ls_wen, ls_sign, m_ready, m_rvalid, m_rlast, m_bvalid, m_err;
   logic [31:0] if_addr, ls_addr, ls_wdata, m_rdata;
   logic [7:0]  if_len;
   logic [1:0]  ls_mask;

   logic        if_gnt, if_rvalid, if_rlast, if_err, ls_gnt, ls_done, ls_err;
   logic        m_valid, m_wen, m_sign;
   logic [31:0] if_rdata, ls_rdata, m_addr, m_wdata;
   logic [1:0]  m_mask;
   logic [7:0]  m_len;

   logic        f0_if_gnt, f0_if_rvalid, f0_if_rlast, f0_if_err, f0_ls_gnt, f0_ls_done, f0_ls_err;
   logic        f0_m_valid, f0_m_wen, f0_m_sign;
   logic [31:0] f0_if_rdata, f0_ls_rdata, f0_m_addr, f0_m_wdata;
   logic [1:0]  f0_m_mask;
   logic [7:0]  f0_m_len;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int who;
   int bad;

   always #5 clock = ~clock;

   ysyx_25040111_arb #(.FAIR(1'b1), .AW(32)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rlast(if_rlast), .if_err(if_err),
      .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_mask(ls_mask), .ls_sign(ls_sign), .ls_gnt(ls_gnt), .ls_done(ls_done),
      .ls_rdata(ls_rdata), .ls_err(ls_err),
      .m_valid(m_valid), .m_ready(m_ready), .m_wen(m_wen), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_mask(m_mask), .m_sign(m_sign), .m_len(m_len),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
      .m_bvalid(m_bvalid), .m_err(m_err)
   );

   ysyx_25040111_arb #(.FAIR(1'b0), .AW(32)) dut0 (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_gnt(f0_if_gnt),
      .if_rvalid(f0_if_rvalid), .if_rdata(f0_if_rdata), .if_rlast(f0_if_rlast), .if_err(f0_if_err),
      .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_mask(ls_mask), .ls_sign(ls_sign), .ls_gnt(f0_ls_gnt), .ls_done(f0_ls_done),
      .ls_rdata(f0_ls_rdata), .ls_err(f0_ls_err),
      .m_valid(f0_m_valid), .m_ready(m_ready), .m_wen(f0_m_wen), .m_addr(f0_m_addr),
      .m_wdata(f0_m_wdata), .m_mask(f0_m_mask), .m_sign(f0_m_sign), .m_len(f0_m_len),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
      .m_bvalid(m_bvalid), .m_err(m_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; if_len = 0;
      ls_req = 0; ls_wen = 0; ls_addr = 0; ls_wdata = 0; ls_mask = 0; ls_sign = 0;
      m_ready = 0; m_rvalid = 0; m_rdata = 0; m_rlast = 0; m_bvalid = 0; m_err = 0;
   endtask

   // Waits for a grant on the selected instance, then completes a one-beat transaction.
   task automatic run_one(input bit use_f0, output int win);
      win = -1;
      for (int k = 0; k < 20 && win < 0; k++) begin
         @(negedge clock);
         if (use_f0 ? f0_if_gnt : if_gnt)      win = 0;
         else if (use_f0 ? f0_ls_gnt : ls_gnt) win = 1;
      end
      if (win < 0) return;
      if (win == 0) if_req = 0; else ls_req = 0;
      m_ready = 1;
      @(negedge clock);
      m_rvalid = 1; m_rlast = 1; m_rdata = 32'hA5A5_0000 + 32'(win);
      @(negedge clock);
      m_rvalid = 0; m_rlast = 0;
      $display("txn grant winner=%s", (win == 0) ? "IFU" : "LSU");
   endtask

   initial begin
      idle_inputs();
      m_rvalid = 1;
      repeat (2) @(negedge clock);
      chk("rst_ctrl", {29'd0, m_valid, if_gnt, ls_gnt}, 32'd0);
      chk("rst_fields", {20'd0, m_wen, m_mask, m_sign, m_len}, 32'd0);
      chk("rst_resp", {28'd0, if_rvalid, if_err, ls_done, ls_err}, 32'd0);
      m_rvalid = 0;
      reset = 1;

      // LSU load alone
      @(negedge clock);
      ls_req = 1; ls_addr = 32'h8000_0010; ls_wen = 0; ls_mask = 2'b11; m_ready = 1;
      @(negedge clock);
      chk("t1_ls_gnt", ls_gnt, 1); chk("t1_if_gnt", if_gnt, 0);
      chk("t1_m_valid", m_valid, 1); chk("t1_m_addr", m_addr, 32'h8000_0010);
      ls_req = 0;
      @(negedge clock);
      chk("t1_m_valid_drop", m_valid, 0); chk("t1_gnt_pulse", ls_gnt, 0);
      m_rvalid = 1; m_rlast = 1; m_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t1_ls_done", ls_done, 1); chk("t1_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
      chk("t1_if_quiet", {if_rvalid, if_err}, 0);
      @(negedge clock);
      m_rlast = 0;
      #1;
      chk("t1_idle_stray", {ls_done, if_rvalid}, 0);
      m_rvalid = 0;
      $display("txn lsu load addr=80000010");

      // IFU 8-beat refill with m_ready held off
      if_req = 1; if_addr = 32'h8000_1000; if_len = 7; m_ready = 0;
      @(negedge clock);
      chk("t2_if_gnt", if_gnt, 1); chk("t2_m_len", m_len, 7);
      chk("t2_m_mask", m_mask, 2'b11); chk("t2_m_wen", m_wen, 0);
      if_req = 0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_m_valid_hold", m_valid, 1);
         chk("t2_m_addr_hold", m_addr, 32'h8000_1000);
         if (i == 3) m_ready = 1;
         @(negedge clock);
      end
      chk("t2_m_valid_drop", m_valid, 0);
      m_ready = 0;
      for (int b = 0; b < 8; b++) begin
         m_rvalid = 1; m_rdata = 32'h1000_0000 + 32'(b); m_rlast = (b == 7);
         #1;
         chk("t2_rvalid", if_rvalid, 1);
         chk("t2_rdata", if_rdata, 32'h1000_0000 + 32'(b));
         chk("t2_rlast", if_rlast, 32'(b == 7));
         chk("t2_err", if_err, 0);
         @(negedge clock);
      end
      m_rlast = 0;
      #1;
      chk("t2_idle_stray", if_rvalid, 0);
      m_rvalid = 0;
      $display("txn ifu refill 8 beats");

      // Round-robin with both requesting
      if_len = 0;
      for (int r = 0; r < 4; r++) begin
         if_req = 1; ls_req = 1;
         run_one(1'b0, who);
         chk("t3_fair_winner", 32'(who), (r % 2 == 0) ? 32'd1 : 32'd0);
      end
      if_req = 0; ls_req = 0;

      // Fixed LSU priority on the FAIR=0 instance
      reset = 0;
      @(negedge clock);
      reset = 1;
      m_ready = 1;
      if_req = 1; ls_req = 1;
      run_one(1'b1, who);
      chk("t4_prio_first", 32'(who), 1);
      ls_req = 1;
      run_one(1'b1, who);
      chk("t4_prio_second", 32'(who), 1);
      run_one(1'b1, who);
      chk("t4_ifu_after_drop", 32'(who), 0);
      if_req = 0;

      // Store completing with an error; strobes in REQ ignored
      reset = 0;
      @(negedge clock);
      reset = 1;
      ls_req = 1; ls_wen = 1; ls_addr = 32'h8000_0020; ls_wdata = 32'h1234_5678;
      ls_mask = 2'b01; ls_sign = 1; m_ready = 0;
      @(negedge clock);
      chk("t5_ls_gnt", ls_gnt, 1); chk("t5_m_wen", m_wen, 1);
      chk("t5_m_wdata", m_wdata, 32'h1234_5678);
      chk("t5_m_mask_sign", {m_mask, m_sign}, 3'b011); chk("t5_m_len", m_len, 0);
      ls_req = 0; m_bvalid = 1; m_err = 1;
      #1;
      chk("t5_req_stray", {ls_done, ls_err}, 0);
      m_bvalid = 0; m_err = 0; m_ready = 1;
      @(negedge clock);
      m_bvalid = 1; m_err = 1; m_rdata = 32'hFFFF_FFFF;
      #1;
      chk("t5_ls_done", ls_done, 1); chk("t5_ls_err", ls_err, 1); chk("t5_ls_rdata", ls_rdata, 0);
      @(negedge clock);
      m_bvalid = 0; m_err = 0; m_rdata = 0; ls_wen = 0; ls_sign = 0;
      $display("txn lsu store err");

      // Refill len=3 with early m_rlast on beat 2
      if_req = 1; if_addr = 32'h8000_2000; if_len = 3;
      @(negedge clock);
      chk("t6_if_gnt", if_gnt, 1);
      if_req = 0;
      @(negedge clock);
      m_rvalid = 1; m_rlast = 0; m_rdata = 32'h2;
      #1;
      chk("t6_beat1_err", {if_err, if_rlast}, 0);
      @(negedge clock);
      m_rlast = 1;
      #1;
      chk("t6_beat2_rvalid", if_rvalid, 1); chk("t6_beat2_err", if_err, 1);
      chk("t6_beat2_rlast", if_rlast, 0);
      @(negedge clock);
      m_rlast = 0;
      #1;
      chk("t6_no_more_beats", if_rvalid, 0); chk("t6_state", 32'(dut.state_reg), 0);
      m_rvalid = 0;
      $display("txn ifu refill early rlast");

      // 256-beat refill must not wrap the beat counter
      if_req = 1; if_len = 8'd255;
      @(negedge clock);
      chk("t7_if_gnt", if_gnt, 1);
      if_req = 0;
      @(negedge clock);
      bad = 0;
      for (int b = 0; b < 256; b++) begin
         m_rvalid = 1; m_rlast = (b == 255);
         #1;
         if (if_rvalid !== 1'b1 || if_err !== 1'b0 || if_rlast !== (b == 255)) bad++;
         @(negedge clock);
      end
      m_rvalid = 0; m_rlast = 0;
      chk("t7_bad_beats", 32'(bad), 0); chk("t7_state", 32'(dut.state_reg), 0);
      $display("txn ifu refill 256 beats");

      // Asynchronous reset during a refill response
      if_req = 1; if_len = 3;
      @(negedge clock);
      if_req = 0;
      @(negedge clock);
      m_rvalid = 1; m_rdata = 32'h55;
      #1;
      chk("t8_in_resp", if_rvalid, 1);
      reset = 0;
      #1;
      chk("t8_async_out", {if_rvalid, if_err, m_valid, if_gnt}, 0);
      chk("t8_async_state", 32'(dut.state_reg), 0);
      @(negedge clock);
      m_rvalid = 0; reset = 1;
      ls_req = 1; ls_addr = 32'h8000_0040;
      @(negedge clock);
      chk("t8_regrant", ls_gnt, 1); chk("t8_regrant_addr", m_addr, 32'h8000_0040);
      ls_req = 0;
      $display("txn reset abort then lsu grant");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
